pulse_event_capture: RTL
========================

# pulse_event_capture

Timestamps and measures every pulse on the synchronized detector line and queues one event record per pulse for readout. It sits directly downstream of the `synchronizer` stage, in parallel with the delay buffer, on the `synchronized_pulse` net of one channel. Each record holds the rising-edge time from a free-running counter and the pulse width in clock cycles. Records are held in a small show-ahead queue with a valid/ready interface, and overflow is counted instead of stalling.

## Interface
Parameters:
- `TS_WIDTH`, 32: width of the free-running timestamp counter and of `o_ts`.
- `WIDTH_BITS`, 16: width of the pulse-width field.
- `DEPTH`, 16: event queue depth, a power of two, at least 2.
- `MIN_WIDTH`, 2: pulses shorter than this many cycles are discarded as glitches.
- `DEADTIME`, 4: cycles ignored after each accepted or discarded pulse; 0 disables dead time.

Ports:
- `clk`, in, 1: system clock (100 MHz domain).
- `rst`, in, 1: reset, asynchronous and active-high.
- `i_signal`, in, 1: synchronized pulse, already in the `clk` domain.
- `o_ts`, out, `TS_WIDTH`: head-of-queue rising-edge timestamp.
- `o_width`, out, `WIDTH_BITS`: head-of-queue pulse width in cycles.
- `o_valid`, out, 1: the queue is non-empty and the head is valid.
- `i_ready`, in, 1: consumer accepts the head.
- `o_full`, out, 1: the queue is full.
- `o_drop_count`, out, 16: number of events lost to a full queue; saturates.

## Operation
- `ts_cnt`: resets to 0, increments every cycle, wraps modulo 2^`TS_WIDTH`.
- `prev`: registered copy of `i_signal`, reset value 1. A line that is held high through reset therefore produces no event until it goes low and then high again.
- Rising edge: `i_signal`=1 and `prev`=0 at a clock edge.
- FSM states, reset state IDLE:
  - IDLE: on a rising edge, latch `ts_cnt` into the pending timestamp, set width to 1, go to HIGH.
  - HIGH: while `i_signal`=1, increment width, saturating at 2^`WIDTH_BITS`−1 and staying in HIGH. When `i_signal`=0:
    - if width ≥ `MIN_WIDTH`, push {ts, width};
    - go to DEAD when `DEADTIME`>0, otherwise to IDLE.
  - DEAD: a counter runs for `DEADTIME` cycles, then returns to IDLE. Edges during DEAD are ignored, and a line still high on exit is not an edge.
- Push while full with no pop in the same cycle: the event is discarded and `o_drop_count` increments, saturating at 0xFFFF.
- Push while full with a pop in the same cycle: the push is accepted and the count is unchanged.
- Pop: occurs when `o_valid` and `i_ready` are both high. The head advances on that edge.
- Output stability: `o_ts` and `o_width` stay stable while `o_valid` is high and `i_ready` is low.
- Reset values: `o_valid`=0, `o_full`=0, `o_drop_count`=0. `o_ts` and `o_width` are 0 (memory contents are don't-care, but the head register is cleared).
- Reset asserted mid-pulse or mid-queue: the in-flight pulse and all queued events are lost, and all pointers and counters clear immediately.

## Timing
- Timestamp: `ts_cnt` value at the rising-edge clock edge (before that edge's increment).
- Width: the number of clock edges that sampled `i_signal`=1.
- Push happens on the falling-edge clock edge F. `o_valid` rises in the cycle after F, so latency is 1 cycle from the sampled falling edge.
- Empty queue with simultaneous push and pop is impossible, because `o_valid`=0.
- Shortest back-to-back pulses: the next edge is accepted no earlier than F+`DEADTIME`+1.
- Pointers: log2(`DEPTH`)+1 bits. Full and empty are derived from the MSB and index comparison.

## Structure
- Shared package `muon_daq_pkg` holds:
  - `pec_state_t` enum {IDLE, HIGH, DEAD};
  - `pulse_event_t` packed struct {ts, width};
  - the drop-counter width constant 16.
- Sub-module `event_fifo`: a synchronous show-ahead FIFO parameterized by `DEPTH` and data width. It has push, pop, full and empty, plus async reset. It is reusable for other channels.
- The top level holds the timestamp counter, edge detector, FSM, width and dead-time counters, and drop accounting.

## Test plan
- Reset release, then `i_signal` high for edges at ts 10–14 → `o_valid` rises after the falling edge at 15; `o_ts`=10, `o_width`=5.
- A 1-cycle glitch with `MIN_WIDTH`=2 → no event and `o_drop_count`=0. A 2-cycle pulse → event with width 2.
- `DEADTIME`=4: pulse A falls at F, pulse B rises at F+2 → only A is recorded. A rise at F+5 → recorded.
- `i_ready`=0 with 18 pulses → 16 queued, `o_full`=1, `o_drop_count`=2. Drain with `i_ready`=1 → timestamps come out in order and `o_valid` drops after the 16th pop.
- `TS_WIDTH`=8 with a pulse rising at ts 255 and another at ts 300 → `o_ts`=255, then 44 (wrap). `WIDTH_BITS`=4 with a 20-cycle pulse → width 15.
- Assert `rst` in the middle of a pulse with 3 events queued → `o_valid`=0 immediately. After release with `i_signal` still high, there is no event until a fresh low-to-high transition.

Source files
------------

// File: rtl/muon_daq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muon_daq_pkg
// Purpose  : Shared types and constants for the muon DAQ pulse channels.
// Revision : 1.0 - initial release
// ============================================================================
package muon_daq_pkg;

    localparam int c_drop_cnt_width = 16;
    localparam int c_def_ts_width   = 32;
    localparam int c_def_width_bits = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        DEAD = 2'd2
    } pec_state_t;

    // Record layout at the default channel widths; FIFO words use the same order.
    typedef struct packed {
        logic [c_def_ts_width-1:0]   ts;
        logic [c_def_width_bits-1:0] width;
    } pulse_event_t;

endpackage
`default_nettype wire

// File: rtl/event_fifo.sv
`default_nettype none
// ============================================================================
// Module   : event_fifo
// Purpose  : Show-ahead synchronous FIFO with async reset, one extra pointer bit.
// Revision : 1.0 - initial release
// ============================================================================
module event_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0]           wr_ptr_q, wr_ptr_d;
    logic [c_aw:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    w_wr_en;
    logic                    w_rd_en;

    always_comb begin
        o_empty  = (wr_ptr_q == rd_ptr_q);
        o_full   = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                   (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
        w_rd_en  = i_pop & ~o_empty;
        // A full FIFO still accepts a write when the head leaves on the same edge.
        w_wr_en  = i_push & (~o_full | w_rd_en);
        wr_ptr_d = w_wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = w_rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        o_data   = o_empty ? '0 : mem_q[rd_ptr_q[c_aw-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q[c_aw-1:0]] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pulse_event_capture.sv
`default_nettype none
// ============================================================================
// Module   : pulse_event_capture
// Purpose  : Timestamps and measures pulses on one channel, queues event records.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_event_capture
    import muon_daq_pkg::*;
#(
    parameter int TS_WIDTH   = 32,
    parameter int WIDTH_BITS = 16,
    parameter int DEPTH      = 16,
    parameter int MIN_WIDTH  = 2,
    parameter int DEADTIME   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_signal,
    output logic [TS_WIDTH-1:0]         o_ts,
    output logic [WIDTH_BITS-1:0]       o_width,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_full,
    output logic [c_drop_cnt_width-1:0] o_drop_count
);

    localparam int                     c_ew        = TS_WIDTH + WIDTH_BITS;
    localparam int                     c_dcw       = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [WIDTH_BITS-1:0]  c_width_max = '1;
    localparam logic [WIDTH_BITS-1:0]  c_min_w     = WIDTH_BITS'(MIN_WIDTH);
    localparam logic [c_dcw-1:0]       c_dead_load = c_dcw'((DEADTIME > 0) ? DEADTIME - 1 : 0);

    pec_state_t                   state_q, state_d;
    logic [TS_WIDTH-1:0]          ts_cnt_q, ts_cnt_d;
    logic [TS_WIDTH-1:0]          ts_pend_q, ts_pend_d;
    logic [WIDTH_BITS-1:0]        width_q, width_d;
    logic [c_dcw-1:0]             dead_q, dead_d;
    logic [c_drop_cnt_width-1:0]  drop_q, drop_d;
    logic                         prev_q, prev_d;

    logic                         w_rise;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_fifo_full;
    logic                         w_fifo_empty;
    logic [c_ew-1:0]              w_head;

    always_comb begin
        ts_cnt_d  = ts_cnt_q + 1'b1;
        prev_d    = i_signal;
        state_d   = state_q;
        ts_pend_d = ts_pend_q;
        width_d   = width_q;
        dead_d    = dead_q;
        w_push    = 1'b0;
        w_rise    = i_signal & ~prev_q;

        case (state_q)
            IDLE: begin
                if (w_rise) begin
                    ts_pend_d = ts_cnt_q;
                    width_d   = WIDTH_BITS'(1);
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                if (i_signal) begin
                    if (width_q != c_width_max) begin
                        width_d = width_q + 1'b1;
                    end
                end else begin
                    w_push = (width_q >= c_min_w);
                    if (DEADTIME > 0) begin
                        state_d = DEAD;
                        dead_d  = c_dead_load;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DEAD: begin
                // Last dead cycle returns to IDLE so the next edge lands at F+DEADTIME+1.
                if (dead_q == '0) begin
                    state_d = IDLE;
                end else begin
                    dead_d = dead_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_pop  = ~w_fifo_empty & i_ready;
        drop_d = drop_q;
        if (w_push && w_fifo_full && !w_pop && (drop_q != '1)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ts_cnt_q  <= '0;
            ts_pend_q <= '0;
            width_q   <= '0;
            dead_q    <= '0;
            drop_q    <= '0;
            prev_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            ts_cnt_q  <= ts_cnt_d;
            ts_pend_q <= ts_pend_d;
            width_q   <= width_d;
            dead_q    <= dead_d;
            drop_q    <= drop_d;
            prev_q    <= prev_d;
        end
    end

    event_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (c_ew)
    ) u_event_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({ts_pend_q, width_q}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign o_ts         = w_head[c_ew-1:WIDTH_BITS];
    assign o_width      = w_head[WIDTH_BITS-1:0];
    assign o_valid      = ~w_fifo_empty;
    assign o_full       = w_fifo_full;
    assign o_drop_count = drop_q;

endmodule
`default_nettype wire
